// File: rtl/mips_cpu_muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package mips_cpu_muldiv_pkg;

    typedef enum logic [1:0] {
        MULT  = 2'd0,
        MULTU = 2'd1,
        DIV   = 2'd2,
        DIVU  = 2'd3
    } op_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int MULDIV_ITERS = 32;

    function automatic logic [31:0] abs32(input logic [31:0] v);
        abs32 = v[31] ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/mips_cpu_divstep.sv
// One restoring-divide step: shift in the next dividend bit, subtract if it fits.
module mips_cpu_divstep
    import mips_cpu_muldiv_pkg::*;
(
    input  logic [31:0] rem,
    input  logic [31:0] quot,
    input  logic [31:0] divisor,
    output logic [31:0] rem_next,
    output logic [31:0] quot_next
);

    logic [32:0] shifted_s;
    logic [31:0] diff_s;

    // trial subtraction; the difference always fits 32 bits when it is kept
    always_comb begin
        shifted_s = {rem, quot[31]};
        diff_s    = shifted_s[31:0] - divisor;
        if (shifted_s >= {1'b0, divisor}) begin
            rem_next  = diff_s;
            quot_next = {quot[30:0], 1'b1};
        end else begin
            rem_next  = shifted_s[31:0];
            quot_next = {quot[30:0], 1'b0};
        end
    end

endmodule

// File: rtl/mips_cpu_muldiv.sv
// Iterative MIPS multiply/divide unit holding the architectural HI/LO registers.
module mips_cpu_muldiv
    import mips_cpu_muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             RESET,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] RsDATA,
    input  logic [WIDTH-1:0] RtDATA,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_t      state_r;
    op_t         op_r;
    logic [4:0]  count_r;
    logic [31:0] a_r;
    logic [31:0] b_r;
    logic [63:0] acc_r;
    logic        neg_res_r;
    logic        neg_rem_r;
    logic        div_zero_r;
    logic [31:0] hi_r;
    logic [31:0] lo_r;
    logic        busy_r;
    logic        done_r;

    logic        signed_op_s;
    logic [31:0] a_in_s;
    logic [31:0] b_in_s;
    logic [32:0] mul_sum_s;
    logic [63:0] acc_next_s;
    logic [63:0] prod_fix_s;
    logic [31:0] rem_next_s;
    logic [31:0] quot_next_s;
    logic [31:0] hi_res_s;
    logic [31:0] lo_res_s;

    // acc_r holds {remainder, shifting dividend/quotient} during a divide
    mips_cpu_divstep u_divstep (
        .rem       (acc_r[63:32]),
        .quot      (acc_r[31:0]),
        .divisor   (b_r),
        .rem_next  (rem_next_s),
        .quot_next (quot_next_s)
    );

    // operand conditioning at launch: signed ops work on magnitudes
    always_comb begin
        signed_op_s = ~op[0];
        if (signed_op_s) begin
            a_in_s = abs32(RsDATA);
            b_in_s = abs32(RtDATA);
        end else begin
            a_in_s = RsDATA;
            b_in_s = RtDATA;
        end
    end

    // next iteration value and sign-corrected final result
    always_comb begin
        mul_sum_s  = {1'b0, acc_r[63:32]} + (acc_r[0] ? {1'b0, a_r} : 33'd0);
        if (op_r[1]) begin
            acc_next_s = {rem_next_s, quot_next_s};
        end else begin
            acc_next_s = {mul_sum_s, acc_r[31:1]};
        end
        prod_fix_s = neg_res_r ? (64'd0 - acc_next_s) : acc_next_s;
        case (op_r)
            MULT, MULTU: begin
                hi_res_s = prod_fix_s[63:32];
                lo_res_s = prod_fix_s[31:0];
            end
            DIV, DIVU: begin
                hi_res_s = neg_rem_r ? (32'd0 - rem_next_s) : rem_next_s;
                if (div_zero_r) begin
                    lo_res_s = 32'hFFFF_FFFF;
                end else begin
                    lo_res_s = neg_res_r ? (32'd0 - quot_next_s) : quot_next_s;
                end
            end
            default: begin
                hi_res_s = 32'd0;
                lo_res_s = 32'd0;
            end
        endcase
    end

    // control FSM, iteration state and HI/LO
    always_ff @(posedge clk) begin
        if (RESET) begin
            state_r    <= IDLE;
            op_r       <= MULT;
            count_r    <= 5'd0;
            a_r        <= 32'd0;
            b_r        <= 32'd0;
            acc_r      <= 64'd0;
            neg_res_r  <= 1'b0;
            neg_rem_r  <= 1'b0;
            div_zero_r <= 1'b0;
            hi_r       <= 32'd0;
            lo_r       <= 32'd0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        op_r       <= op_t'(op);
                        a_r        <= a_in_s;
                        b_r        <= b_in_s;
                        acc_r      <= op[1] ? {32'd0, a_in_s} : {32'd0, b_in_s};
                        neg_res_r  <= signed_op_s & (RsDATA[31] ^ RtDATA[31]);
                        neg_rem_r  <= signed_op_s & RsDATA[31];
                        div_zero_r <= (RtDATA == 32'd0);
                        count_r    <= 5'd0;
                        busy_r     <= 1'b1;
                        state_r    <= RUN;
                    end else begin
                        if (mthi) hi_r <= RsDATA;
                        if (mtlo) lo_r <= RsDATA;
                    end
                end
                RUN: begin
                    acc_r   <= acc_next_s;
                    count_r <= count_r + 5'd1;
                    if (count_r == 5'(MULDIV_ITERS - 1)) begin
                        hi_r    <= hi_res_s;
                        lo_r    <= lo_res_s;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule
